if_stage_mo: RTL and testbench

Parametrised instruction-fetch stage that keeps up to `OUTSTANDING` instruction-SRAM read requests in flight and buffers returned instructions in a `BUF_DEPTH`-entry queue ahead of the decode stage. It sits between the SRAM-like instruction interface (AXI bridge side) and decode. It replaces the single-outstanding fetch stage. Redirects (exception, ertn, branch) flush the queue and silently drop responses to squashed requests using a cancel counter, so no per-ID tracking is needed.

---
 rtl/if_stage_mo.sv | 144 ++++++++++++++
 tb/tb_if_stage_mo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_mo.sv
// if_stage_mo: multi-outstanding instruction fetch stage with an instruction queue ahead of decode.
// Redirects flush the queue and a cancel counter drops responses to squashed requests. (rev 1.0)
`default_nettype none

module if_stage_mo #(
  parameter int          OUTSTANDING = 2,
  parameter int          BUF_DEPTH   = 4,
  parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic        br_taken,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus
);

  localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int QW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW  = $clog2(OUTSTANDING + 1);
  localparam int QCW = QW + 1;

  logic [31:0]    pf_pc;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  cancel_cnt;
  logic [CW-1:0]  inflight_next;
  logic [31:0]    pc_fifo [OUTSTANDING];
  logic [PW-1:0]  pc_wptr;
  logic [PW-1:0]  pc_rptr;
  logic [64:0]    iq [BUF_DEPTH];
  logic [QW-1:0]  q_wptr;
  logic [QW-1:0]  q_rptr;
  logic [QCW-1:0] q_count;
  logic           adef_halt;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic        credit_ok;
  logic        accept;
  logic        resp_live;
  logic        adef_push;
  logic        q_push;
  logic        q_pop;
  logic [64:0] push_data;

  function automatic logic [PW-1:0] pc_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == QW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect = wb_ex | ertn_flush | br_taken;

  always_comb begin
    redirect_pc = br_target;
    if (ertn_flush) redirect_pc = ertn_entry;
    if (wb_ex)      redirect_pc = ex_entry;
  end

  assign misaligned = (pf_pc[1:0] != 2'b00);
  // Reserve a queue slot for every live response before asking for another.
  assign credit_ok  = (32'(inflight) - 32'(cancel_cnt) + 32'(q_count)) < 32'(BUF_DEPTH);

  assign inst_sram_req = resetn & ~redirect & ~br_stall & ~adef_halt & ~misaligned &
                         (32'(inflight) < 32'(OUTSTANDING)) & credit_ok;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = pf_pc;
  assign inst_sram_wdata = 32'h0;

  assign accept        = inst_sram_req & inst_sram_addr_ok;
  assign inflight_next = inflight + CW'(accept) - CW'(inst_sram_data_ok);
  assign resp_live     = inst_sram_data_ok & (cancel_cnt == '0);
  assign adef_push     = misaligned & ~adef_halt & (inflight == cancel_cnt) &
                         (q_count < QCW'(BUF_DEPTH));
  assign q_push        = (resp_live | adef_push) & ~redirect;
  assign q_pop         = fs_to_ds_valid & ds_allowin;
  assign push_data     = adef_push ? {1'b1, 32'h0, pf_pc}
                                   : {1'b0, inst_sram_rdata, pc_fifo[pc_rptr]};

  assign fs_to_ds_valid = (q_count != '0);
  assign fs_to_ds_bus   = fs_to_ds_valid ? iq[q_rptr] : 65'h0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pf_pc      <= RESET_PC;
      inflight   <= '0;
      cancel_cnt <= '0;
      pc_wptr    <= '0;
      pc_rptr    <= '0;
      q_wptr     <= '0;
      q_rptr     <= '0;
      q_count    <= '0;
      adef_halt  <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (accept)            pc_wptr <= pc_inc(pc_wptr);
      if (inst_sram_data_ok) pc_rptr <= pc_inc(pc_rptr);
      if (redirect) begin
        pf_pc      <= redirect_pc;
        adef_halt  <= 1'b0;
        cancel_cnt <= inflight_next;
        q_wptr     <= '0;
        q_rptr     <= '0;
        q_count    <= '0;
      end else begin
        if (accept)    pf_pc     <= pf_pc + 32'd4;
        if (adef_push) adef_halt <= 1'b1;
        if (inst_sram_data_ok && cancel_cnt != '0) cancel_cnt <= cancel_cnt - 1'b1;
        if (q_push) q_wptr <= q_inc(q_wptr);
        if (q_pop)  q_rptr <= q_inc(q_rptr);
        q_count <= q_count + QCW'(q_push) - QCW'(q_pop);
      end
    end
  end

  // Storage arrays carry no reset; the pointers and counts qualify every read.
  always_ff @(posedge clk) begin
    if (accept) pc_fifo[pc_wptr] <= pf_pc;
    if (q_push) iq[q_wptr]       <= push_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage_mo.sv
// tb_if_stage_mo: randomized bench for if_stage_mo against a generation-tagged queue model.
`default_nettype none

module tb_if_stage_mo;

  localparam int          OUT   = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        wb_ex = 1'b0, ertn_flush = 1'b0, br_taken = 1'b0;
  logic [31:0] ex_entry = 32'h0, ertn_entry = 32'h0, br_target = 32'h0;
  logic        br_stall = 1'b0, ds_allowin = 1'b0;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  if_stage_mo #(.OUTSTANDING(OUT), .BUF_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .br_taken(br_taken),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .br_target(br_target),
    .br_stall(br_stall), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each request is tagged with the redirect generation it was issued in.
  typedef struct {
    logic [31:0] pc;
    int          gen;
  } fl_t;

  fl_t         m_fl[$];
  logic [64:0] m_iq[$];
  logic [31:0] m_pc = RPC;
  logic        m_halt = 1'b0;
  int          m_gen = 0;
  logic [31:0] br_q[$];

  int k_addr = 100, k_data = 100, k_allow = 100, k_redir = 0, k_stall = 0, k_mis = 0;

  logic        cap_req, cap_valid;
  logic [31:0] cap_addr;
  logic [64:0] cap_bus;
  int          n_acc = 0, n_pop = 0, n_req = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = RPC + ($urandom_range(0, 1023) << 2);
    if (pct(k_mis)) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic rand_inputs();
    inst_sram_addr_ok = pct(k_addr);
    inst_sram_data_ok = resetn && (br_q.size() > 0) && pct(k_data);
    inst_sram_rdata   = inst_sram_data_ok ? br_q[0] : $urandom;
    ds_allowin = pct(k_allow);
    br_stall   = pct(k_stall);
    wb_ex      = pct(k_redir);
    ertn_flush = pct(k_redir);
    br_taken   = pct(k_redir);
    ex_entry   = rand_tgt();
    ertn_entry = rand_tgt();
    br_target  = rand_tgt();
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one clock.
  task automatic tick();
    int          live;
    logic        redir, mis, exp_req, adefp, acc_dut, pop;
    logic [31:0] tgt;
    logic [64:0] exp_bus;
    fl_t         e;
    #1;
    live = 0;
    foreach (m_fl[i]) if (m_fl[i].gen == m_gen) live++;
    redir   = wb_ex | ertn_flush | br_taken;
    tgt     = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
    mis     = (m_pc[1:0] != 2'b00);
    exp_req = resetn && !redir && !br_stall && !m_halt && !mis &&
              (m_fl.size() < OUT) && ((live + m_iq.size()) < DEPTH);
    adefp   = resetn && mis && !m_halt && (live == 0) && (m_iq.size() < DEPTH) && !redir;
    exp_bus = (m_iq.size() > 0) ? m_iq[0] : 65'h0;
    check("req", 65'(inst_sram_req), 65'(exp_req));
    check("addr", 65'(inst_sram_addr), 65'(m_pc));
    check("valid", 65'(fs_to_ds_valid), 65'(m_iq.size() > 0));
    check("bus", fs_to_ds_bus, exp_bus);
    cap_req   = inst_sram_req;
    cap_valid = fs_to_ds_valid;
    cap_bus   = fs_to_ds_bus;
    cap_addr  = inst_sram_addr;
    acc_dut   = inst_sram_req && inst_sram_addr_ok;
    pop       = (m_iq.size() > 0) && ds_allowin;
    if (acc_dut) n_acc++;
    if (cap_valid && ds_allowin) n_pop++;
    if (cap_req) n_req++;
    @(posedge clk);
    if (!resetn) begin
      m_fl.delete(); m_iq.delete(); br_q.delete();
      m_pc = RPC; m_halt = 1'b0; m_gen++;
    end else begin
      if (inst_sram_data_ok) void'(br_q.pop_front());
      if (acc_dut) br_q.push_back($urandom);
      if (pop) void'(m_iq.pop_front());
      if (inst_sram_data_ok && m_fl.size() > 0) begin
        e = m_fl.pop_front();
        if (e.gen == m_gen && !redir) m_iq.push_back({1'b0, inst_sram_rdata, e.pc});
      end
      if (adefp) begin
        m_iq.push_back({1'b1, 32'h0, m_pc});
        m_halt = 1'b1;
      end
      if (redir) begin
        m_iq.delete();
        m_gen++;
        m_pc = tgt;
        m_halt = 1'b0;
      end else if (exp_req && inst_sram_addr_ok) begin
        m_fl.push_back('{pc: m_pc, gen: m_gen});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      tick();
    end
  endtask

  task automatic wait_valid(input string tag, input int maxc, output logic [64:0] bus);
    bus = 65'h0;
    for (int i = 0; i < maxc; i++) begin
      rand_inputs();
      tick();
      if (cap_valid) begin
        bus = cap_bus;
        return;
      end
    end
    check({tag, "_timeout"}, 65'(cap_valid), 65'(1'b1));
  endtask

  logic [64:0] head;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wr", 65'(inst_sram_wr), 65'(1'b0));
    check("size", 65'(inst_sram_size), 65'(2'b10));
    check("wstrb", 65'(inst_sram_wstrb), 65'(4'h0));
    check("wdata", 65'(inst_sram_wdata), 65'(32'h0));
    run(2);

    // Back-to-back handshakes give one instruction per cycle.
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) n_pop = 0;
      rand_inputs();
      tick();
    end
    check("throughput", 65'(n_pop), 65'(30));

    // Withheld responses: accepts stop at the outstanding limit.
    k_addr = 0; k_data = 100; run(6);
    k_addr = 100; k_data = 0; n_acc = 0; run(10);
    check("accepts", 65'(n_acc), 65'(OUT));
    k_addr = 0; k_data = 100; run(6);

    // Decode stalled: queue fills, then drains.
    k_addr = 100; k_data = 60; k_allow = 0; run(30);
    k_allow = 100; run(20);

    // Branch squashes two in-flight requests.
    k_addr = 0; k_data = 100; run(6);
    k_addr = 100; k_data = 0; run(3);
    rand_inputs(); br_taken = 1'b1; br_target = 32'h1c000100; tick();
    k_data = 100;
    wait_valid("br", 30, head);
    check("br_pc", 65'(head[31:0]), 65'(32'h1c000100));

    // Exception beats a branch in the same cycle.
    run(5);
    rand_inputs(); wb_ex = 1'b1; br_taken = 1'b1;
    ex_entry = 32'h1c000200; br_target = 32'h1c000300; tick();
    rand_inputs(); tick();
    check("ex_win", 65'(cap_addr), 65'(32'h1c000200));
    check("flush_valid", 65'(cap_valid), 65'(1'b0));

    // Misaligned branch target raises one adef entry and halts fetch.
    run(5);
    rand_inputs(); br_taken = 1'b1; br_target = 32'h1c000102; tick();
    wait_valid("adef", 30, head);
    check("adef_entry", head, {1'b1, 32'h0, 32'h1c000102});
    n_req = 0; run(6);
    check("adef_halt", 65'(n_req), 65'(0));
    rand_inputs(); wb_ex = 1'b1; ex_entry = 32'h1c000400; tick();
    wait_valid("resume", 30, head);
    check("resume_pc", 65'(head[31:0]), 65'(32'h1c000400));

    // Random traffic with redirects, misaligned targets and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        k_addr  = $urandom_range(20, 100);
        k_data  = $urandom_range(20, 100);
        k_allow = $urandom_range(0, 100);
        k_redir = $urandom_range(0, 8);
        k_stall = $urandom_range(0, 30);
        k_mis   = $urandom_range(0, 30);
      end
      resetn = !pct(1);
      rand_inputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
